// File: rtl/skip_arith_pkg.sv
// Shared constants and types for the carry-skip arithmetic blocks.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package skip_arith_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_BLOCK = 4;

    // Status flags that travel alongside an arithmetic result.
    typedef struct packed {
        logic bout;
        logic ovf;
        logic zero;
    } res_flags_t;

    // Number of carry-skip groups (and therefore pipeline stages).
    function automatic int calc_ng(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/skip_sub_group.sv
// One BLOCK-bit carry-skip group of a subtractor: sum = a + ~b + cin.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline stage owns flow control.
//
// Ports: a, b   - operand slices (b is inverted internally)
//        cin    - carry into the group (active-high carry, i.e. not-borrow)
//        sum    - group sum bits
//        cout   - carry out, taken from cin when every bit propagates
module skip_sub_group
    import skip_arith_pkg::*;
#(
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout
);

    logic [BLOCK-1:0] bn;
    logic [BLOCK-1:0] prop;
    logic [BLOCK-1:0] gen;
    logic [BLOCK:0]   rip;
    logic             prop_all;

    always_comb begin
        bn       = ~b;
        prop     = a ^ bn;
        gen      = a & bn;
        rip      = '0;
        rip[0]   = cin;
        for (int i = 0; i < BLOCK; i++) begin
            rip[i+1] = gen[i] | (prop[i] & rip[i]);
        end
        sum      = prop ^ rip[BLOCK-1:0];
        // Skip only on a true XOR propagate across the whole group; a bit
        // that generates or kills must force the rippled carry.
        prop_all = &prop;
        cout     = prop_all ? cin : rip[BLOCK];
    end

endmodule

// File: rtl/skip_subtractor_pipe.sv
// Pipelined subtractor diff = a - b - bin, one carry-skip group per stage.
// Latency: NG = WIDTH/BLOCK cycles from accepted input to out_valid; one result per cycle.
// Backpressure: a stage moves when empty or when the stage after it moves; bubbles collapse behind a stall.
//
// Ports: clk/rst_n (async active-low), in_valid/in_ready + a, b, bin on the
//        input side; out_valid/out_ready + diff, bout, ovf, zero on the output.
// Build option SKIP_SUB_SAT_EN adds input sat: a captured sat with a borrow
//        clamps diff to 0 (zero=1) while bout/ovf still report the raw result.
module skip_subtractor_pipe
    import skip_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BLOCK = DEF_BLOCK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef SKIP_SUB_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NG  = calc_ng(WIDTH, BLOCK);
    localparam int MSB = WIDTH - 1;

    // Stage state: operands ride along so later groups can consume their
    // slices; dif holds the sum bits produced so far; brw is the borrow
    // into the next group (stored inverted so reset reads as "no borrow").
    logic [NG-1:0]    v_q, v_d;
    logic [NG-1:0]    brw_q, brw_d;
    logic [WIDTH-1:0] a_q   [NG];
    logic [WIDTH-1:0] a_d   [NG];
    logic [WIDTH-1:0] b_q   [NG];
    logic [WIDTH-1:0] b_d   [NG];
    logic [WIDTH-1:0] dif_q [NG];
    logic [WIDTH-1:0] dif_d [NG];
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // What each stage sees on its input side.
    logic [NG-1:0]    st_v;
    logic [NG-1:0]    st_brw;
    logic [WIDTH-1:0] st_a   [NG];
    logic [WIDTH-1:0] st_b   [NG];
    logic [WIDTH-1:0] st_dif [NG];
    logic [BLOCK-1:0] grp_sum [NG];
    logic [NG-1:0]    grp_cout;

    logic [NG-1:0]    adv;
    logic [WIDTH-1:0] fin_dif;
    res_flags_t       out_flags;

`ifdef SKIP_SUB_SAT_EN
    logic [NG-1:0]    s_q, s_d;
    logic [NG-1:0]    st_s;
`endif

    for (genvar k = 0; k < NG; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign st_v[k]   = in_valid;
            assign st_a[k]   = a;
            assign st_b[k]   = b;
            assign st_brw[k] = bin;
            assign st_dif[k] = '0;
`ifdef SKIP_SUB_SAT_EN
            assign st_s[k]   = sat;
`endif
        end else begin : g_body
            assign st_v[k]   = v_q[k-1];
            assign st_a[k]   = a_q[k-1];
            assign st_b[k]   = b_q[k-1];
            assign st_brw[k] = brw_q[k-1];
            assign st_dif[k] = dif_q[k-1];
`ifdef SKIP_SUB_SAT_EN
            assign st_s[k]   = s_q[k-1];
`endif
        end

        skip_sub_group #(
            .BLOCK (BLOCK)
        ) u_grp (
            .a    (st_a[k][k*BLOCK +: BLOCK]),
            .b    (st_b[k][k*BLOCK +: BLOCK]),
            .cin  (~st_brw[k]),
            .sum  (grp_sum[k]),
            .cout (grp_cout[k])
        );
    end

    // Advance chain: computed from the output end back to the input so that
    // in_ready depends only on out_ready and the valid bits.
    always_comb begin
        adv       = '0;
        adv[NG-1] = !v_q[NG-1] || out_ready;
        for (int k = NG - 2; k >= 0; k--) begin
            adv[k] = !v_q[k] || adv[k+1];
        end
    end

    assign in_ready = adv[0];

    always_comb begin
        v_d    = v_q;
        brw_d  = brw_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
`ifdef SKIP_SUB_SAT_EN
        s_d    = s_q;
`endif
        for (int k = 0; k < NG; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            dif_d[k] = dif_q[k];
        end

        // Raw final difference as it enters the last stage.
        fin_dif = st_dif[NG-1];
        fin_dif[(NG-1)*BLOCK +: BLOCK] = grp_sum[NG-1];

        for (int k = 0; k < NG; k++) begin
            if (adv[k]) begin
                v_d[k] = st_v[k];
                // A bubble moving in leaves the data registers alone.
                if (st_v[k]) begin
                    a_d[k]   = st_a[k];
                    b_d[k]   = st_b[k];
                    brw_d[k] = ~grp_cout[k];
                    dif_d[k] = st_dif[k];
                    dif_d[k][k*BLOCK +: BLOCK] = grp_sum[k];
`ifdef SKIP_SUB_SAT_EN
                    s_d[k]   = st_s[k];
`endif
                end
            end
        end

        if (adv[NG-1] && st_v[NG-1]) begin
            ovf_d  = (st_a[NG-1][MSB] != st_b[NG-1][MSB]) &&
                     (fin_dif[MSB] != st_a[NG-1][MSB]);
            zero_d = (fin_dif == '0);
`ifdef SKIP_SUB_SAT_EN
            if (st_s[NG-1] && !grp_cout[NG-1]) begin
                dif_d[NG-1] = '0;
                zero_d      = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            brw_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
`ifdef SKIP_SUB_SAT_EN
            s_q    <= '0;
`endif
            for (int k = 0; k < NG; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                dif_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            brw_q  <= brw_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
`ifdef SKIP_SUB_SAT_EN
            s_q    <= s_d;
`endif
            for (int k = 0; k < NG; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                dif_q[k] <= dif_d[k];
            end
        end
    end

    // The last stage's operand copies are never consumed downstream.
    logic unused_tail;
    assign unused_tail = ^{a_q[NG-1], b_q[NG-1]};
`ifdef SKIP_SUB_SAT_EN
    logic unused_tail_sat;
    assign unused_tail_sat = s_q[NG-1];
`endif

    assign out_flags = '{bout: brw_q[NG-1], ovf: ovf_q, zero: zero_q};

    assign out_valid = v_q[NG-1];
    assign diff      = dif_q[NG-1];
    assign bout      = out_flags.bout;
    assign ovf       = out_flags.ovf;
    assign zero      = out_flags.zero;

endmodule

// File: tb/tb_skip_subtractor_pipe.sv
// Randomized and directed bench for skip_subtractor_pipe against an arithmetic model.
// Latency: expects results 2 cycles after acceptance when the pipe is idle.
// Backpressure: toggles out_ready, checks hold stability, ordering and no loss.
module tb_skip_subtractor_pipe;

    localparam int W  = 8;
    localparam int NG = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         sat_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic         zero;

    always #5 clk = ~clk;

    skip_subtractor_pipe #(.WIDTH(W), .BLOCK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
`ifdef SKIP_SUB_SAT_EN
        .sat       (sat_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    typedef struct {
        logic [10:0] res;
        int          cyc;
        bit          exact;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_bad = 0;
    int          n_out = 0;
    int          cyc   = 0;
    bit          acc_flag;
    bit          last_in_ready;
    bit          mark_exact = 0;
    bit          hold_pend  = 0;
    logic [10:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [10:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                          input logic mbin, input logic msat);
        int          ur;
        int          sr;
        logic [7:0]  d;
        logic        bo;
        logic        ov;
        ur = int'(ma) - int'(mb) - int'(mbin);
        bo = (ur < 0);
        d  = 8'((ur + 256) % 256);
        sr = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        ov = (sr < -128) || (sr > 127);
        if (msat && bo) d = 8'h00;
        return {d, bo, ov, (d == 8'h00)};
    endfunction

    function automatic logic sat_now();
`ifdef SKIP_SUB_SAT_EN
        return sat_i;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: entered at a falling edge with inputs driven; observes the
    // handshakes that the coming rising edge will perform.
    task automatic step();
        exp_t e;
        #1;
        if (hold_pend) begin
            chk("hold_vld", out_valid, 1);
            chk("hold_dat", {diff, bout, ovf, zero}, held);
            hold_pend = 0;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_vld", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("result", {diff, bout, ovf, zero}, e.res);
                if (e.exact) chk("latency", cyc - e.cyc, NG);
                n_out++;
            end
        end
        if (out_valid && !out_ready) begin
            hold_pend = 1;
            held      = {diff, bout, ovf, zero};
        end
        last_in_ready = in_ready;
        acc_flag      = in_valid && in_ready;
        if (acc_flag) begin
            e.res   = model(a, b, bin, sat_now());
            e.cyc   = cyc;
            e.exact = mark_exact && (exp_q.size() == 0) && out_ready;
            exp_q.push_back(e);
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain(input string tag);
        in_valid  = 0;
        out_ready = 1;
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) step();
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic send_one(input logic [7:0] ta, input logic [7:0] tb2,
                            input logic tbin, input logic ts);
        bit ok;
        a = ta; b = tb2; bin = tbin; sat_i = ts;
        in_valid = 1; out_ready = 1; mark_exact = 1;
        ok = 0;
        for (int t = 0; t < 10 && !ok; t++) begin
            step();
            ok = acc_flag;
        end
        chk("send_acc", ok, 1);
        in_valid   = 0;
        mark_exact = 0;
        drain("send_drain");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pa [5];
        logic [7:0] pb [5];
        int         sent;
        int         got0;
        bit         saw_low;

        rst_n = 0; in_valid = 0; out_ready = 0;
        a = '0; b = '0; bin = 0; sat_i = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_bout", bout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);
        rst_n = 1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);

        // Directed operand sets: basic, borrow, skip path, overflow, zero.
        send_one(8'h50, 8'h20, 1'b0, 1'b0);
        send_one(8'h00, 8'h01, 1'b0, 1'b0);
        send_one(8'hF0, 8'h0F, 1'b1, 1'b0);
        send_one(8'h80, 8'h01, 1'b0, 1'b0);
        send_one(8'h7F, 8'hFF, 1'b0, 1'b0);
        send_one(8'h33, 8'h33, 1'b0, 1'b0);
        send_one(8'hFF, 8'hFF, 1'b1, 1'b0);
`ifdef SKIP_SUB_SAT_EN
        send_one(8'h10, 8'h20, 1'b0, 1'b1);
        send_one(8'h10, 8'h20, 1'b0, 1'b0);
        send_one(8'h20, 8'h10, 1'b0, 1'b1);
`endif

        // Back-to-back stream with a 3-cycle consumer stall.
        for (int i = 0; i < 5; i++) begin
            pa[i] = 8'($urandom);
            pb[i] = 8'($urandom);
        end
        sent = 0; got0 = n_out; saw_low = 0;
        for (int t = 0; t < 40 && (sent < 5 || exp_q.size() != 0); t++) begin
            if (sent < 5) begin
                in_valid = 1; a = pa[sent]; b = pb[sent]; bin = 1'(t & 1);
            end else begin
                in_valid = 0;
            end
            out_ready = !(t >= 2 && t <= 4);
            step();
            if (acc_flag) sent++;
            if (!last_in_ready) saw_low = 1;
        end
        in_valid = 0;
        chk("bp_in_ready_fell", saw_low, 1);
        chk("bp_delivered", n_out - got0, 5);
        chk("bp_drained", exp_q.size(), 0);

        // Reset with two results in flight.
        out_ready = 0; in_valid = 1; a = 8'h44; b = 8'h11; bin = 0;
        step();
        a = 8'h99; b = 8'h12;
        step();
        in_valid = 0;
        chk("pre_rst_vld", out_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_flags", {bout, ovf, zero}, 0);
        exp_q.delete();
        hold_pend = 0;
        @(negedge clk);
        rst_n = 1; out_ready = 1;
        for (int t = 0; t < 5; t++) step();
        chk("post_rst_out_valid", out_valid, 0);
        chk("post_rst_in_ready", in_ready, 1);

        // Randomized traffic; producer holds operands until accepted.
        in_valid = 0;
        for (int t = 0; t < 300; t++) begin
            if (!in_valid || acc_flag) begin
                in_valid = ($urandom_range(0, 9) < 7);
                a        = 8'($urandom);
                b        = 8'($urandom);
                bin      = 1'($urandom);
                sat_i    = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("rand_drained");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
